// File: rtl/ixu_pkg.sv
// Shared definitions for the integer execution lane result side.
//   XLEN, REG_AW  : default data / register address widths
//   ixu_result_t  : one result-pipeline entry {valid, wr, rd, data}
//   ixu_op_e      : ALU op-code set shared with the ALU
package ixu_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // wr = entry really writes the register file (not a NOP, rd != 0)
  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } ixu_result_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_LUI, OP_NOP
  } ixu_op_e;
endpackage

// File: rtl/ixu_result_fwd_if.sv
// Bus between the IXU result stage and its neighbours (ALU, decode,
// register-file write port).
//   slave  : the result-forwarding block
//   master : the surrounding lane (ALU producer, decode, register file)
// Optional: IXU_FWD_STATS_EN adds fwd_hits / wr_stall_cycles counters.
interface ixu_result_fwd_if #(
  parameter int XLEN   = ixu_pkg::XLEN,
  parameter int REG_AW = ixu_pkg::REG_AW
);
  logic              ex_valid;
  logic              ex_is_nop;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_result;
  logic              ex_ready;
  logic              flush;
  logic [REG_AW-1:0] id_rs1, id_rs2;
  logic              is_rs1_fwd, is_rs2_fwd;
  logic [XLEN-1:0]   rs1_fwd_data, rs2_fwd_data;
  logic              rf_wvalid, rf_wready;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
`ifdef IXU_FWD_STATS_EN
  logic [31:0]       fwd_hits, wr_stall_cycles;

  modport slave (
    input  ex_valid, ex_is_nop, ex_rd, ex_result, flush, id_rs1, id_rs2, rf_wready,
    output ex_ready, is_rs1_fwd, is_rs2_fwd, rs1_fwd_data, rs2_fwd_data,
           rf_wvalid, rf_waddr, rf_wdata, fwd_hits, wr_stall_cycles
  );
  modport master (
    output ex_valid, ex_is_nop, ex_rd, ex_result, flush, id_rs1, id_rs2, rf_wready,
    input  ex_ready, is_rs1_fwd, is_rs2_fwd, rs1_fwd_data, rs2_fwd_data,
           rf_wvalid, rf_waddr, rf_wdata, fwd_hits, wr_stall_cycles
  );
`else
  modport slave (
    input  ex_valid, ex_is_nop, ex_rd, ex_result, flush, id_rs1, id_rs2, rf_wready,
    output ex_ready, is_rs1_fwd, is_rs2_fwd, rs1_fwd_data, rs2_fwd_data,
           rf_wvalid, rf_waddr, rf_wdata
  );
  modport master (
    output ex_valid, ex_is_nop, ex_rd, ex_result, flush, id_rs1, id_rs2, rf_wready,
    input  ex_ready, is_rs1_fwd, is_rs2_fwd, rs1_fwd_data, rs2_fwd_data,
           rf_wvalid, rf_waddr, rf_wdata
  );
`endif
endinterface

// File: rtl/ixu_fwd_match.sv
// Priority search of the result pipeline for one source operand.
//   stg_ok_i   : per stage, entry is valid and writes a register
//   stg_rd_i   : per stage destination register
//   stg_data_i : per stage result
//   rs_i       : source register address (0 never matches)
//   hit_o/data_o : youngest matching stage, or 0/0 on no match
module ixu_fwd_match #(
  parameter int NUM_STAGES = 2,
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5
) (
  input  logic [NUM_STAGES-1:0]             stg_ok_i,
  input  logic [NUM_STAGES-1:0][REG_AW-1:0] stg_rd_i,
  input  logic [NUM_STAGES-1:0][XLEN-1:0]   stg_data_i,
  input  logic [REG_AW-1:0]                 rs_i,
  output logic                              hit_o,
  output logic [XLEN-1:0]                   data_o
);
  // Walk oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (rs_i != '0) begin
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (stg_ok_i[i] && (stg_rd_i[i] == rs_i)) begin
          hit_o  = 1'b1;
          data_o = stg_data_i[i];
        end
      end
    end
  end
endmodule

// File: rtl/ixu_result_fwd.sv
// IXU result pipeline + operand forwarding.
// ALU results pass through NUM_STAGES registers; the last stage retires to
// the register file over a ready/valid port. Stages feed a youngest-first
// forwarding search for the two sources of the bundle entering execute.
//   clk, rst_n : lane clock, async active-low reset
//   bus        : ixu_result_fwd_if.slave (ex_*, flush, id_rs*, fwd, rf_w*)
// Optional: IXU_FWD_STATS_EN adds saturating fwd_hits / wr_stall_cycles.
module ixu_result_fwd
  import ixu_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int XLEN       = ixu_pkg::XLEN,
  parameter int REG_AW     = ixu_pkg::REG_AW
) (
  input logic              clk,
  input logic              rst_n,
  ixu_result_fwd_if.slave  bus
);
  localparam int LAST = NUM_STAGES - 1;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } stage_t;

  stage_t [NUM_STAGES-1:0] stg_q, stg_d;
  logic                    wvalid, adv;
  logic                    hit1, hit2;

  logic [NUM_STAGES-1:0]             stg_ok;
  logic [NUM_STAGES-1:0][REG_AW-1:0] stg_rd;
  logic [NUM_STAGES-1:0][XLEN-1:0]   stg_data;

  // Entries that don't write retire without waiting for the grant.
  assign wvalid       = stg_q[LAST].valid && stg_q[LAST].wr;
  assign adv          = !wvalid || bus.rf_wready;
  assign bus.ex_ready = adv;
  assign bus.rf_wvalid = wvalid;
  assign bus.rf_waddr  = wvalid ? stg_q[LAST].rd   : '0;
  assign bus.rf_wdata  = wvalid ? stg_q[LAST].data : '0;

  always_comb begin
    stg_d = stg_q;
    if (bus.flush) begin
      stg_d = '0;
    end else if (adv) begin
      for (int i = LAST; i > 0; i--) stg_d[i] = stg_q[i-1];
      stg_d[0] = '0;
      if (bus.ex_valid) begin
        stg_d[0].valid = 1'b1;
        stg_d[0].wr    = !bus.ex_is_nop && (bus.ex_rd != '0);
        stg_d[0].rd    = bus.ex_rd;
        stg_d[0].data  = bus.ex_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_flat
    assign stg_ok[g]   = stg_q[g].valid && stg_q[g].wr;
    assign stg_rd[g]   = stg_q[g].rd;
    assign stg_data[g] = stg_q[g].data;
  end

  ixu_fwd_match #(.NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .stg_ok_i(stg_ok), .stg_rd_i(stg_rd), .stg_data_i(stg_data),
    .rs_i(bus.id_rs1), .hit_o(hit1), .data_o(bus.rs1_fwd_data)
  );
  ixu_fwd_match #(.NUM_STAGES(NUM_STAGES), .XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .stg_ok_i(stg_ok), .stg_rd_i(stg_rd), .stg_data_i(stg_data),
    .rs_i(bus.id_rs2), .hit_o(hit2), .data_o(bus.rs2_fwd_data)
  );
  assign bus.is_rs1_fwd = hit1;
  assign bus.is_rs2_fwd = hit2;

`ifdef IXU_FWD_STATS_EN
  logic [31:0] fwd_hits_q, fwd_hits_d, stall_q, stall_d;
  logic [32:0] hits_sum;

  always_comb begin
    hits_sum   = {1'b0, fwd_hits_q} + 33'(hit1) + 33'(hit2);
    fwd_hits_d = hits_sum[32] ? '1 : hits_sum[31:0];
    stall_d    = stall_q;
    if (wvalid && !bus.rf_wready && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hits_q <= '0;
      stall_q    <= '0;
    end else begin
      fwd_hits_q <= fwd_hits_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.fwd_hits        = fwd_hits_q;
  assign bus.wr_stall_cycles = stall_q;
`endif
endmodule
